loadstore_unit: RTL
===================

// Module: loadstore_unit
// PURPOSE
//  MIPS memory-stage access controller between pipeline and datamemory (word-addressed, RW_RD=0 write / 1 read).
//  Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
//  Extracts and extends load data; performs read-modify-write for sub-word stores; flags misaligned accesses.
//  Big-endian lanes throughout.
// PARAMETERS
//  DATA_WIDTH  32  memory word width (fixed 32 for lane logic)
//  ADDR_WIDTH  10  datamemory word-address width; byte address is ADDR_WIDTH+2 bits
// PORTS
//  CLK        in   1               system clock, rising edge
//  RST        in   1               asynchronous, active-high reset
//  req        in   1               request strobe, accepted only when busy=0
//  we         in   1               1=store, 0=load
//  size       in   2               00 byte, 01 half, 10 word, 11 illegal
//  uns        in   1               loads: 1=zero-extend, 0=sign-extend
//  addr       in   ADDR_WIDTH+2    byte address
//  wdata      in   32              store data, right-justified
//  busy       out  1               request in flight
//  done       out  1               one-cycle completion pulse
//  err        out  1               misaligned/illegal; valid with done
//  rdata      out  32              extended load result; held until next load completes
//  mem_ADDR   out  ADDR_WIDTH      to datamemory ADDR = addr[ADDR_WIDTH+1:2]
//  mem_RW_RD  out  1               to datamemory RW_RD; 0 only in state WR
//  mem_din    out  32              to datamemory din
//  mem_dout   in   32              from datamemory dout; valid 1 cycle after read address
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE, busy=0, done=0, err=0, rdata=0, mem_ADDR=0, mem_din=0.
//   - mem_RW_RD=1 at once, so an in-flight write is killed.
//  Accept: at edge with req=1, busy=0; latch we/size/uns/addr/wdata; busy=1 from next cycle.
//   - req while busy is ignored, with no queueing.
//  Misaligned: size=01 and addr[0]=1, size=10 and addr[1:0]!=0, or size=11.
//   - Goes to DONE with err=1; no memory access; rdata unchanged.
//  States and transitions:
//   - IDLE -> RD (load / SB / SH), WR (SW), or DONE (misaligned).
//   - RD -> CAP: mem_ADDR driven, mem_RW_RD=1.
//   - CAP -> DONE (load) or WR (sub-word store):
//       load: rdata <= extended lane of mem_dout.
//       store: merge buffer <= mem_dout with the target lane replaced.
//   - WR -> DONE: mem_RW_RD=0, mem_din = buffer (SW: wdata); memory writes at the WR-ending edge.
//   - DONE -> IDLE: done=1, busy=0 (a new req may be accepted at this edge).
//  Lanes (big-endian):
//   - byte: addr[1:0]=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
//   - half: addr[1]=0 -> [31:16], 1 -> [15:0].
//  Extension: uns=0 replicates the lane MSB; uns=1 pads with zeros; word loads are unextended.
//  Latency (cycles from accepting edge to done high): misaligned 1, SW 2, load 3, SB/SH 4.
//  Store inputs: only wdata[7:0] (SB) or wdata[15:0] (SH) are used; the other lanes are preserved.
//  Stores never modify rdata.
//  mem_RW_RD=1 in every state except WR; no glitch to 0 outside WR.
// TESTING
//  - Reset: RST=1 mid-SB in WR state -> mem_RW_RD=1 immediately; target word unchanged; all outputs at reset values.
//  - SW addr=0x010, wdata=0xDEADBEEF -> word 4 = 0xDEADBEEF; done 2 cycles after accept.
//  - SB addr=0x012, wdata=0x000000AA over 0xDEADBEEF -> word 4 = 0xDEAAAAEF? no: 0xDEADAAEF; done after 4 cycles.
//  - LB addr=0x012 (uns=0) -> rdata=0xFFFFFFAA; LHU addr=0x010 -> 0x0000DEAD; done after 3 cycles.
//  - LH addr=0x011 -> done+err after 1 cycle; no RW_RD=0 pulse; rdata unchanged.
//  - req held high during SB: second req ignored until DONE; back-to-back SW then LW to same word returns the new value.
```

Correction to test line 3 (the line above contains a stray note): SB addr=0x012, wdata=0x000000AA over 0xDEADBEEF -> word 4 = 0xDEADAAEF; done 4 cycles after accept.

Source files
------------

// File: rtl/loadstore_unit.sv
// Memory-stage load/store controller for a word-addressed datamemory with registered read.
// Converts byte-addressed sub-word accesses into word reads, lane extraction and read-modify-write.
module loadstore_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_uns,
  input  logic [ADDR_WIDTH+1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rw_rd,
  output logic [DATA_WIDTH-1:0] o_mem_din,
  input  logic [DATA_WIDTH-1:0] i_mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [15:0]           r_wdata;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_rw_rd;
  logic [7:0]            w_lane_byte;
  logic [15:0]           w_lane_half;
  logic [DATA_WIDTH-1:0] w_load_ext;
  logic [3:0]            w_lane_mask;
  logic [DATA_WIDTH-1:0] w_store_rep;
  logic [DATA_WIDTH-1:0] w_merge;

  // DONE also accepts, so back-to-back requests lose no cycle.
  assign w_accept = i_req && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_misaligned = (i_size == 2'b11) ||
                        ((i_size == 2'b01) && i_addr[0]) ||
                        ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_rw_rd      = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (w_accept) begin
          if (w_misaligned) begin
            w_state_next = S_DONE;
          end else if (i_we && (i_size == 2'b10)) begin
            w_state_next = S_WR;
          end else begin
            w_state_next = S_RD;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RD: begin
        w_busy       = 1'b1;
        w_state_next = S_CAP;
      end
      S_CAP: begin
        w_busy       = 1'b1;
        w_state_next = r_we ? S_WR : S_DONE;
      end
      S_WR: begin
        w_busy       = 1'b1;
        w_rw_rd      = 1'b0;
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Big-endian lane extraction and extension of the captured word.
  always_comb begin
    w_lane_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: w_lane_byte = i_mem_dout[31:24];
      2'd1: w_lane_byte = i_mem_dout[23:16];
      2'd2: w_lane_byte = i_mem_dout[15:8];
      2'd3: w_lane_byte = i_mem_dout[7:0];
      default: w_lane_byte = 8'h00;
    endcase
    w_lane_half = r_addr[1] ? i_mem_dout[15:0] : i_mem_dout[31:16];
    case (r_size)
      2'b00:   w_load_ext = r_uns ? {24'h000000, w_lane_byte}
                                  : {{24{w_lane_byte[7]}}, w_lane_byte};
      2'b01:   w_load_ext = r_uns ? {16'h0000, w_lane_half}
                                  : {{16{w_lane_half[15]}}, w_lane_half};
      default: w_load_ext = i_mem_dout;
    endcase
  end

  assign w_store_rep = (r_size == 2'b00) ? {4{r_wdata[7:0]}} : {2{r_wdata[15:0]}};

  // Lane gi is byte gi in big-endian order: lane 0 is bits [31:24].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane_mask[gi] = (r_size == 2'b00) ? (r_addr[1:0] == 2'(gi))
                                               : (r_addr[1] == 1'(gi / 2));
    assign w_merge[31-8*gi -: 8] = w_lane_mask[gi] ? w_store_rep[31-8*gi -: 8]
                                                   : i_mem_dout[31-8*gi -: 8];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 16'h0000;
      r_buf   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= i_we;
        r_size  <= i_size;
        r_uns   <= i_uns;
        r_addr  <= i_addr;
        r_wdata <= i_wdata[15:0];
        r_err   <= w_misaligned;
        // A full-word store skips the read, so its data goes straight to the write buffer.
        if (i_we && (i_size == 2'b10)) begin
          r_buf <= i_wdata;
        end
      end else if (r_state == S_CAP) begin
        if (r_we) begin
          r_buf <= w_merge;
        end else begin
          r_rdata <= w_load_ext;
        end
      end
    end
  end

  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_err       = w_done && r_err;
  assign o_rdata     = r_rdata;
  assign o_mem_addr  = r_addr[ADDR_WIDTH+1:2];
  assign o_mem_rw_rd = w_rw_rd;
  assign o_mem_din   = r_buf;

endmodule
